// File: rtl/food_spawner.sv
// Food placer for the snake board: draws cells from a free-running LFSR and
// accepts the first on-board cell that no live snake segment occupies.
module food_spawner #(
  parameter int          MAX_LEN  = 64,
  parameter int          POS_BITS = 13,
  parameter int          GRID_W   = 100,
  parameter int          GRID_H   = 75,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         food_eaten,
  input  logic                         move_tick,
  input  logic                         restart,
  input  logic [POS_BITS*MAX_LEN-1:0]  snake_body_flat,
  input  logic [6:0]                   snake_length,
  output logic [POS_BITS-1:0]          food_pos,
  output logic                         food_valid,
  output logic                         busy
);

  localparam int unsigned CELLS = GRID_W * GRID_H;
  localparam int          SEL_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [6:0]  MAX_L = 7'(MAX_LEN);

  typedef enum logic [1:0] {DRAW, SCAN, READY} state_t;

  state_t                             state, state_nx;
  logic [15:0]                        lfsr;
  logic [POS_BITS-1:0]                cand, cand_nx, seg;
  logic [6:0]                         idx, idx_nx, len_eff;
  logic [MAX_LEN-1:0][POS_BITS-1:0]   body;
  logic                               draw_ok, accept, valid_clr;

  assign body    = snake_body_flat;
  assign len_eff = (snake_length > MAX_L) ? MAX_L : snake_length;
  assign draw_ok = 32'(lfsr[POS_BITS-1:0]) < 32'(CELLS);
  // idx only reaches MAX_LEN on the accept cycle, where seg is not used
  assign seg     = body[idx[SEL_W-1:0]];
  assign busy    = (state != READY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= SEED;
    else        lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    state_nx  = state;
    cand_nx   = cand;
    idx_nx    = idx;
    accept    = 1'b0;
    valid_clr = 1'b0;
    if (restart) begin
      state_nx  = DRAW;
      idx_nx    = '0;
      valid_clr = 1'b1;
    end else begin
      case (state)
        DRAW: begin
          if (draw_ok) begin
            cand_nx  = lfsr[POS_BITS-1:0];
            idx_nx   = '0;
            state_nx = SCAN;
          end
        end
        SCAN: begin
          // body moved under us: rescan the same candidate from the head
          if (move_tick)            idx_nx = '0;
          else if (idx >= len_eff) begin
            accept   = 1'b1;
            state_nx = READY;
          end
          else if (seg == cand)     state_nx = DRAW;
          else                      idx_nx = idx + 7'd1;
        end
        READY: begin
          if (food_eaten) begin
            state_nx  = DRAW;
            valid_clr = 1'b1;
          end
        end
        default: state_nx = DRAW;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= DRAW;
      cand       <= '0;
      idx        <= '0;
      food_pos   <= '0;
      food_valid <= 1'b0;
    end else begin
      state <= state_nx;
      cand  <= cand_nx;
      idx   <= idx_nx;
      if (valid_clr) food_valid <= 1'b0;
      else if (accept) begin
        food_pos   <= cand;
        food_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_food_spawner.sv
// Scoreboard bench for food_spawner: a reference LFSR/placement model predicts
// each placement (cell and edge) and a monitor compares it when food_valid rises.
module tb_food_spawner;

  localparam int MAX_LEN = 64;
  localparam int PB      = 13;
  localparam int CELLS   = 7500;

  typedef struct {int pos; int due;} sb_t;

  logic                   clk = 1'b0, rst_n = 1'b0;
  logic                   food_eaten = 1'b0, move_tick = 1'b0, restart = 1'b0;
  logic [PB*MAX_LEN-1:0]  flat;
  logic [6:0]             length;
  logic [PB-1:0]          food_pos, food_pos2;
  logic                   food_valid, busy, food_valid2, busy2;
  logic [PB-1:0]          body [MAX_LEN];
  logic [15:0]            m_lfsr;
  int                     checks = 0, errors = 0, ecnt = 0;
  int                     last_scan0, planted_c;
  sb_t                    sb[$];
  sb_t                    last_p, mon_e;
  bit                     pv;

  food_spawner u_dut (
    .clk(clk), .rst_n(rst_n), .food_eaten(food_eaten), .move_tick(move_tick),
    .restart(restart), .snake_body_flat(flat), .snake_length(length),
    .food_pos(food_pos), .food_valid(food_valid), .busy(busy));

  food_spawner #(.SEED(16'h1FFF)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .food_eaten(food_eaten), .move_tick(move_tick),
    .restart(restart), .snake_body_flat(flat), .snake_length(length),
    .food_pos(food_pos2), .food_valid(food_valid2), .busy(busy2));

  function automatic logic [15:0] lstep(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic int eff_len();
    return (int'(length) > MAX_LEN) ? MAX_LEN : int'(length);
  endfunction

  function automatic int body_hit(input int p);
    for (int j = 0; j < eff_len(); j++) if (int'(body[j]) == p) return 1;
    return 0;
  endfunction

  // v is the LFSR value sampled at edge d; in_scan starts at SCAN idx 0 with cand c0
  function automatic sb_t predict(input logic [15:0] v, input int d, input bit in_scan,
                                  input int c0, output int scan0);
    logic [15:0] l;
    int e, c, hit, L;
    bit scanning;
    sb_t r;
    l = v; e = d; c = c0; scanning = in_scan; L = eff_len();
    r.pos = -1; r.due = -1; scan0 = -1;
    for (int it = 0; it < 20000; it++) begin
      if (!scanning) begin
        c = int'(l[12:0]);
        l = lstep(l);
        e++;
        if (c >= CELLS) continue;
      end
      hit = -1;
      for (int j = 0; j < L; j++) if (hit < 0 && int'(body[j]) == c) hit = j;
      if (hit < 0) begin
        r.pos = c; r.due = e + L; scan0 = e;
        return r;
      end
      for (int k = 0; k <= hit; k++) l = lstep(l);
      e += hit + 1;
      scanning = 0;
    end
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int n = 0;
    while (sb.size() != 0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      check(tag, sb.size(), 0);
      sb.delete();
    end
  endtask

  // eat from READY; optionally plant the first in-range candidate at segment 2
  task automatic eat(input int hold, input bit plant);
    int prev, s0;
    logic [15:0] l;
    sb_t p;
    @(negedge clk);
    prev = int'(food_pos);
    if (plant) begin
      l = lstep(m_lfsr);
      while (int'(l[12:0]) >= CELLS) l = lstep(l);
      planted_c = int'(l[12:0]);
      body[2] = l[12:0];
    end
    food_eaten = 1'b1;
    p = predict(lstep(m_lfsr), ecnt + 2, 1'b0, 0, s0);
    sb.push_back(p);
    last_p = p;
    last_scan0 = s0;
    @(negedge clk);
    check("eat_valid_drop", int'(food_valid), 0);
    check("eat_busy", int'(busy), 1);
    check("eat_pos_hold", int'(food_pos), prev);
    for (int k = 1; k < hold; k++) begin
      if (food_valid) food_eaten = 1'b0;
      @(negedge clk);
    end
    food_eaten = 1'b0;
  endtask

  always #5 clk = ~clk;

  always @(posedge clk) ecnt <= ecnt + 1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= lstep(m_lfsr);
  end

  always_comb begin
    flat = '0;
    for (int i = 0; i < MAX_LEN; i++) flat[i*PB +: PB] = body[i];
  end

  always @(posedge clk) begin
    #1;
    if (!rst_n) pv = 1'b0;
    else begin
      if (food_valid && !pv) begin
        if (sb.size() == 0) check("spurious_place", 1, 0);
        else begin
          mon_e = sb.pop_front();
          check("place_pos", int'(food_pos), mon_e.pos);
          check("place_edge", ecnt, mon_e.due);
        end
      end
      pv = food_valid;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at edge %0d", ecnt);
    $fatal(1);
  end

  initial begin
    sb_t p, p2;
    int s0, old, prev;
    bit seen2;
    length = 7'd3;
    for (int i = 0; i < MAX_LEN; i++) body[i] = 13'(i + 10);
    repeat (3) @(negedge clk);
    check("rst_valid", int'(food_valid), 0);
    check("rst_pos", int'(food_pos), 0);
    check("rst_busy", int'(busy), 1);
    check("rst_valid2", int'(food_valid2), 0);
    check("rst_busy2", int'(busy2), 1);

    p  = predict(16'hACE1, ecnt + 1, 1'b0, 0, s0);
    p2 = predict(16'h1FFF, ecnt + 1, 1'b0, 0, s0);
    sb.push_back(p);
    rst_n = 1'b1;
    seen2 = 1'b0;
    for (int n = 0; n < 60 && !(seen2 && sb.size() == 0); n++) begin
      @(negedge clk);
      if (!seen2 && food_valid2) begin
        seen2 = 1'b1;
        check("seed2_edge", ecnt, p2.due);
        check("seed2_pos", int'(food_pos2), p2.pos);
        check("seed2_range", int'(int'(food_pos2) < CELLS), 1);
      end
    end
    if (!seen2) check("seed2_timeout", 0, 1);
    wait_idle("first_timeout", 50);
    check("first_pos", int'(food_pos), 3297);

    // segment 2 sits on the first candidate
    length = 7'd5;
    for (int k = 0; k < 5; k++) body[k] = 13'(7300 + k);
    eat(1, 1'b1);
    wait_idle("hit_timeout", 400);
    check("hit_avoid", body_hit(int'(food_pos)), 0);
    check("hit_rejected", int'(int'(food_pos) == planted_c), 0);

    // food_eaten held until the new food is placed
    for (int k = 0; k < 5; k++) body[k] = 13'(200 + 37 * k);
    eat(10, 1'b0);
    wait_idle("hold_timeout", 400);
    old = int'(food_pos);
    repeat (5) @(negedge clk);
    check("hold_valid", int'(food_valid), 1);
    check("hold_idle", int'(busy), 0);
    check("hold_pos", int'(food_pos), old);

    // move_tick at SCAN idx 3 puts segment 1 onto the candidate
    for (int k = 0; k < 5; k++) body[k] = 13'(5000 + k);
    eat(1, 1'b0);
    for (int n = 0; n < 400 && ecnt < last_scan0 + 2; n++) @(negedge clk);
    old = last_p.pos;
    move_tick = 1'b1;
    body[1] = 13'(old);
    void'(sb.pop_back());
    sb.push_back(predict(lstep(m_lfsr), ecnt + 2, 1'b1, old, s0));
    @(negedge clk);
    move_tick = 1'b0;
    wait_idle("tick_timeout", 400);
    check("tick_avoid", body_hit(int'(food_pos)), 0);
    check("tick_rejected", int'(int'(food_pos) == old), 0);

    // restart on the acceptance edge wins
    length = 7'd4;
    for (int k = 0; k < 4; k++) body[k] = 13'(6000 + k);
    prev = int'(food_pos);
    eat(1, 1'b0);
    for (int n = 0; n < 400 && ecnt < last_p.due - 1; n++) @(negedge clk);
    restart = 1'b1;
    void'(sb.pop_back());
    sb.push_back(predict(lstep(m_lfsr), ecnt + 2, 1'b0, 0, s0));
    @(negedge clk);
    restart = 1'b0;
    check("rs_valid", int'(food_valid), 0);
    check("rs_busy", int'(busy), 1);
    check("rs_pos_hold", int'(food_pos), prev);
    wait_idle("rs_timeout", 400);
    check("rs_final_valid", int'(food_valid), 1);
    check("rs_avoid", body_hit(int'(food_pos)), 0);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
